// File: rtl/bt656_pkg.sv
// bt656_pkg: shared constants and state types for the BT.656 timing decoder
// TRS preamble codes on bits 9:2, XYZ bit positions, standard line lengths,
// detector and lock state enums.
package bt656_pkg;
    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;
    localparam int XYZ_ONE = 9;
    localparam int XYZ_F = 8;
    localparam int XYZ_V = 7;
    localparam int XYZ_H = 6;
    localparam int XYZ_P3 = 5;
    localparam int XYZ_P0 = 2;
    localparam int LINE_525 = 1716;
    localparam int LINE_625 = 1728;
    typedef enum logic [1:0] {IDLE, P1, P2, P3} trs_state_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
endpackage

// File: rtl/bt656_timing_decoder_if.sv
// bt656_timing_decoder_if: video word in, delayed word plus recovered timing out
// data_in: BT.656 word from the decoder; data_out: data_in delayed 1 cycle;
// F/V/H: timing flags; line_count: EAVs since last F change;
// locked: flywheel lock; trs_error: rejected-XYZ pulse.
// master = stream source / timing consumer, slave = the decoder.
interface bt656_timing_decoder_if;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic       F;
    logic       V;
    logic       H;
    logic [9:0] line_count;
    logic       locked;
    logic       trs_error;
    modport master (output data_in, input data_out, F, V, H, line_count, locked, trs_error);
    modport slave (input data_in, output data_out, F, V, H, line_count, locked, trs_error);
endinterface

// File: rtl/bt656_xyz_check.sv
// bt656_xyz_check: combinational XYZ protection check and optional correction
// xyz: bits 9:2 of the candidate XYZ word; valid: word accepted;
// f/v/h: (corrected) flags. Macro BT656_ECC_EN enables single-bit correction.
module bt656_xyz_check
    import bt656_pkg::*;
(
    input  logic [9:2] xyz,
    output logic       valid,
    output logic       f,
    output logic       v,
    output logic       h
);
    logic [3:0] syn;
    always_comb begin
        syn = xyz[XYZ_P3:XYZ_P0] ^ {xyz[XYZ_V] ^ xyz[XYZ_H], xyz[XYZ_F] ^ xyz[XYZ_H],
                                    xyz[XYZ_F] ^ xyz[XYZ_V], xyz[XYZ_F] ^ xyz[XYZ_V] ^ xyz[XYZ_H]};
`ifdef BT656_ECC_EN
        // a flag error disturbs three parity bits; a one-hot syndrome is a parity-bit error
        f = xyz[XYZ_F] ^ (syn == 4'b0111);
        v = xyz[XYZ_V] ^ (syn == 4'b1011);
        h = xyz[XYZ_H] ^ (syn == 4'b1101);
        valid = xyz[XYZ_ONE] && (syn inside {4'b0000, 4'b0111, 4'b1011, 4'b1101,
                                             4'b1000, 4'b0100, 4'b0010, 4'b0001});
`else
        f = xyz[XYZ_F];
        v = xyz[XYZ_V];
        h = xyz[XYZ_H];
        valid = xyz[XYZ_ONE] && syn == 4'b0000;
`endif
    end
endmodule

// File: rtl/bt656_timing_decoder.sv
// bt656_timing_decoder: BT.656 TRS detection, F/V/H recovery, line flywheel and lock
// clk: 27 MHz word clock; reset_n: async active-low reset;
// bus (slave): data_in in; data_out, F, V, H, line_count, locked, trs_error out.
// Macro BT656_ECC_EN (in bt656_xyz_check) enables single-bit XYZ correction.
module bt656_timing_decoder
    import bt656_pkg::*;
#(
    parameter int LINE_SAMPLES = LINE_525,
    parameter int LOCK_COUNT   = 2,
    parameter int MISS_LIMIT   = 2
) (
    input logic clk,
    input logic reset_n,
    bt656_timing_decoder_if.slave bus
);
    localparam logic [10:0] LAST   = 11'(LINE_SAMPLES - 1);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_COUNT);
    localparam logic [7:0]  MISS_N = 8'(MISS_LIMIT);

    trs_state_t  trs, trs_nxt;
    lock_state_t lock, lock_nxt;
    logic [10:0] cnt;
    logic [7:0]  good_cnt, good_nxt, miss_cnt, miss_nxt;
    logic [7:0]  w;
    logic        xvalid, xf, xv, xh, is_xyz, ok, eav, at_end, synth;

    bt656_xyz_check u_chk (.xyz(bus.data_in[9:2]), .valid(xvalid), .f(xf), .v(xv), .h(xh));

    assign w      = bus.data_in[9:2];
    assign is_xyz = trs == P3;
    assign ok     = is_xyz && xvalid;
    assign eav    = ok && xh;
    assign at_end = cnt == LAST;
    // a valid XYZ on the expiry cycle takes precedence over the flywheel
    assign synth  = lock == LOCKED && at_end && !ok;
    assign bus.locked = lock == LOCKED;

    // FF in P3 is the XYZ word itself, so P3 always returns to IDLE
    always_comb
        trs_nxt = trs == IDLE ? (w == TRS_FF ? P1 : IDLE)
                : trs == P1   ? (w == TRS_00 ? P2 : w == TRS_FF ? P1 : IDLE)
                : trs == P2   ? (w == TRS_00 ? P3 : IDLE)
                : IDLE;

    always_comb begin
        lock_nxt = lock;
        good_nxt = good_cnt;
        miss_nxt = miss_cnt;
        if (eav) begin
            miss_nxt = '0;
            good_nxt = at_end ? (good_cnt == 8'hFF ? good_cnt : good_cnt + 8'd1) : 8'd1;
            lock_nxt = !at_end ? UNLOCKED : good_nxt >= LOCK_N ? LOCKED : lock;
        end else if (synth) begin
            miss_nxt = miss_cnt + 8'd1;
            if (miss_nxt == MISS_N) begin
                lock_nxt = UNLOCKED;
                good_nxt = '0;
                miss_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            trs            <= IDLE;
            lock           <= UNLOCKED;
            good_cnt       <= '0;
            miss_cnt       <= '0;
            cnt            <= '0;
            bus.data_out   <= '0;
            bus.F          <= 1'b0;
            bus.V          <= 1'b1;
            bus.H          <= 1'b1;
            bus.line_count <= '0;
            bus.trs_error  <= 1'b0;
        end else begin
            trs           <= trs_nxt;
            lock          <= lock_nxt;
            good_cnt      <= good_nxt;
            miss_cnt      <= miss_nxt;
            cnt           <= (eav || synth) ? '0 : cnt == 11'h7FF ? cnt : cnt + 11'd1;
            bus.data_out  <= bus.data_in;
            bus.trs_error <= is_xyz && !xvalid;
            if (ok) begin
                bus.F <= xf;
                bus.V <= xv;
                bus.H <= xh;
            end else if (synth)
                bus.H <= 1'b1;
            if (ok && xf != bus.F)
                bus.line_count <= '0;
            else if ((eav || synth) && bus.line_count != 10'h3FF)
                bus.line_count <= bus.line_count + 10'd1;
        end
endmodule

// File: doc/bt656_timing_decoder.md
# bt656_timing_decoder

Recovers BT.656 timing from the 10-bit 4:2:2 stream delivered by the TVP5147M1 decoder. Detects EAV/SAV timing reference sequences (TRS), checks their protection bits and produces registered F/V/H flags, a line counter and a lock indication. Its outputs drive the line-rotation scrambler directly: `data_out`, `V` and `H` connect to that stage's `data_in`, `V` and `H` inputs. A line flywheel keeps H toggling across corrupted or missing EAV codes once lock is established.

## Interface
Parameters:
- `LINE_SAMPLES`, default 1716: words per line, EAV to EAV; 1716 for 525/60, 1728 for 625/50.
- `LOCK_COUNT`, default 2: consecutive correctly spaced EAVs needed to assert lock.
- `MISS_LIMIT`, default 2: consecutive missing EAVs that drop lock.

Ports:
- `clk`, in, 1: pixel-word clock (27 MHz).
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `data_in`, in, 10: BT.656 word from the decoder.
- `data_out`, out, 10: `data_in` delayed by 1 cycle.
- `F`, out, 1: field flag.
- `V`, out, 1: vertical blanking flag.
- `H`, out, 1: horizontal flag; 1 from EAV to SAV.
- `line_count`, out, 10: EAVs counted since the last F change.
- `locked`, out, 1: flywheel locked.
- `trs_error`, out, 1: one-cycle pulse when an XYZ word is rejected.

## Operation
- TRS detector states:
  - IDLE → P1 when `data_in[9:2]`==8'hFF.
  - P1 → P2 when `data_in[9:2]`==8'h00; otherwise back to IDLE, or stay in P1 if the word is FF.
  - P2 → P3 when the word is 00; otherwise IDLE.
  - P3: the next word is XYZ; always return to IDLE after it.
  - An FF word in P3 is treated as XYZ, not as a restart.
- XYZ layout: bit9=1, bit8=F, bit7=V, bit6=H, bits5..2=P3..P0.
  - Expected protection: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - Bits1..0 are ignored.
- Valid XYZ: bit9=1 and syndrome zero (or correctable; see Configuration). F/V/H are updated from it.
- Invalid XYZ: flags are held and `trs_error` pulses.
- Flywheel sample counter, 11 bits, saturating at 2047:
  - cleared on the cycle of every valid EAV (H=1) XYZ word, or of a synthesized EAV;
  - increments otherwise.
- Lock FSM states UNLOCKED, LOCKED:
  - good_cnt increments when a valid EAV arrives with counter == LINE_SAMPLES-1.
  - UNLOCKED → LOCKED when good_cnt reaches LOCK_COUNT.
  - An EAV at any other position resets good_cnt to 1 and resynchronises the counter. In LOCKED it also forces UNLOCKED.
- Missing EAV in LOCKED (counter reaches LINE_SAMPLES-1 with no valid EAV):
  - synthesize an EAV: H←1, F/V held, counter cleared, miss_cnt++;
  - miss_cnt==MISS_LIMIT → UNLOCKED and good_cnt←0.
  - A valid EAV clears miss_cnt.
- In UNLOCKED there is no synthesis; H changes only on valid XYZ words.
- `line_count`:
  - cleared when a valid XYZ word changes F;
  - otherwise increments on each valid or synthesized EAV;
  - saturates at 1023.
- A valid XYZ word and a flywheel expiry on the same cycle: the valid XYZ word wins and no miss is counted.

## Timing
- `data_out` has a latency of 1 cycle.
- F/V/H, `line_count` and `trs_error` are registered on the XYZ input cycle.
- Their new values therefore appear together with `data_out` equal to that XYZ word. H falls coincident with the XYZ word of the SAV, and the next word is the first active sample.
- `locked` updates 1 cycle after the deciding XYZ word.
- Reset values: `data_out`=0, F=0, V=1, H=1, `line_count`=0, `locked`=0, `trs_error`=0.
- Internal reset values: detector IDLE, counters 0.
- Reset asserted mid-line: all state returns to the reset values. Lock is re-acquired from scratch after reset release.

## Configuration
- Macro: `BT656_ECC_EN`.
- Defined: single-bit errors in F/V/H/P3..P0 are corrected by the standard syndrome lookup. Corrected XYZ words are treated as valid and `trs_error` does not pulse. Uncorrectable syndromes are rejected.
- Undefined: any nonzero syndrome rejects the word.

## Structure
- Shared package `bt656_pkg` holds:
  - TRS constants (FF, 00 on bits 9:2);
  - the XYZ bit positions;
  - line-length constants 1716 and 1728;
  - the detector state enum.
- One sub-module, `bt656_xyz_check`: combinational syndrome computation and correction, including the `BT656_ECC_EN` path. Outputs valid, F, V, H.

## Test plan
- Clean 525-line stream, LINE_SAMPLES=1716 → `locked` rises after the 2nd correctly spaced EAV; H falls on the cycle `data_out` shows the SAV XYZ (e.g. 0x200 for F=0, V=0).
- Single-bit flip in an EAV XYZ (0x274 → 0x234):
  - with `BT656_ECC_EN`: H=1 on time and no `trs_error`;
  - without it: `trs_error` pulses and, while locked, the flywheel synthesizes H=1 exactly 1716 cycles after the previous EAV.
- Two consecutive EAVs removed while locked → two synthesized EAVs, then `locked`=0.
- EAV shifted 4 words early while locked → immediate unlock; counter resyncs; relock after 2 further good lines.
- Field switch (F 0→1 in an EAV XYZ) → `line_count` reads 0 on that cycle, then 1 after the next EAV.
- `reset_n` pulsed low mid-active-line → outputs show the reset values asynchronously; `locked` stays 0 until 2 good EAVs follow release.
